// File: rtl/source_c_pkg.sv
// source_c shared types: TileLink C opcodes, FSM states, beat entry layout.
// Also fixes the block geometry and the store/FIFO timing constants.
package source_c_pkg;

   localparam int DATA_W        = 128;
   localparam int BLOCK_BEATS   = 4;
   localparam int WAY_W         = 3;
   localparam int SET_W         = 10;
   localparam int TAG_W         = 12;
   localparam int SOURCE_W      = 6;
   localparam int BS_LAT        = 2;
   localparam int DEPTH         = 4;
   localparam int BLOCK_SIZE_LG = 6;
   localparam int BEAT_W        = $clog2(BLOCK_BEATS);
   localparam int CNT_W         = $clog2(DEPTH + 1);
   localparam int FILL_W        = $clog2(DEPTH + BS_LAT + 1);

   localparam logic [2:0] PROBE_ACK      = 3'd4;
   localparam logic [2:0] PROBE_ACK_DATA = 3'd5;
   localparam logic [2:0] RELEASE        = 3'd6;
   localparam logic [2:0] RELEASE_DATA   = 3'd7;

   typedef enum logic {IDLE, ISSUE} state_e;

   typedef struct packed {
      logic [2:0]          opcode;
      logic [2:0]          param;
      logic [SOURCE_W-1:0] source;
      logic [TAG_W-1:0]    tag;
      logic [SET_W-1:0]    set;
      logic [WAY_W-1:0]    way;
   } req_t;

   typedef struct packed {
      logic [2:0]          opcode;
      logic [2:0]          param;
      logic [SOURCE_W-1:0] source;
      logic [31:0]         address;
      logic [DATA_W-1:0]   data;
   } beat_t;

   function automatic logic [31:0] block_addr(
      input logic [TAG_W-1:0] tag,
      input logic [SET_W-1:0] set
   );
      return {{(32 - TAG_W - SET_W - BLOCK_SIZE_LG){1'b0}},
              tag, set, {BLOCK_SIZE_LG{1'b0}}};
   endfunction

endpackage

// File: rtl/source_c_if.sv
// source_c bus bundle: MSHR request, banked-store read, outbound C channel.
// master = the C source itself, slave = its environment.
interface source_c_if;
   import source_c_pkg::*;

   logic                io_req_valid;
   logic                io_req_ready;
   logic [2:0]          io_req_bits_opcode;
   logic [2:0]          io_req_bits_param;
   logic [SOURCE_W-1:0] io_req_bits_source;
   logic [TAG_W-1:0]    io_req_bits_tag;
   logic [SET_W-1:0]    io_req_bits_set;
   logic [WAY_W-1:0]    io_req_bits_way;

   logic                io_bs_adr_valid;
   logic                io_bs_adr_ready;
   logic                io_bs_adr_bits_noop;
   logic [WAY_W-1:0]    io_bs_adr_bits_way;
   logic [SET_W-1:0]    io_bs_adr_bits_set;
   logic [1:0]          io_bs_adr_bits_beat;
   logic [1:0]          io_bs_adr_bits_mask;
   logic [DATA_W-1:0]   io_bs_dat_data;

   logic                io_c_valid;
   logic                io_c_ready;
   logic [2:0]          io_c_bits_opcode;
   logic [2:0]          io_c_bits_param;
   logic [2:0]          io_c_bits_size;
   logic [SOURCE_W-1:0] io_c_bits_source;
   logic [31:0]         io_c_bits_address;
   logic [DATA_W-1:0]   io_c_bits_data;
   logic                io_c_bits_corrupt;
   logic                io_busy;

   modport master (
      input  io_req_valid, io_req_bits_opcode, io_req_bits_param,
             io_req_bits_source, io_req_bits_tag, io_req_bits_set,
             io_req_bits_way, io_bs_adr_ready, io_bs_dat_data,
             io_c_ready,
      output io_req_ready, io_bs_adr_valid, io_bs_adr_bits_noop,
             io_bs_adr_bits_way, io_bs_adr_bits_set,
             io_bs_adr_bits_beat, io_bs_adr_bits_mask, io_c_valid,
             io_c_bits_opcode, io_c_bits_param, io_c_bits_size,
             io_c_bits_source, io_c_bits_address, io_c_bits_data,
             io_c_bits_corrupt, io_busy
   );

   modport slave (
      output io_req_valid, io_req_bits_opcode, io_req_bits_param,
             io_req_bits_source, io_req_bits_tag, io_req_bits_set,
             io_req_bits_way, io_bs_adr_ready, io_bs_dat_data,
             io_c_ready,
      input  io_req_ready, io_bs_adr_valid, io_bs_adr_bits_noop,
             io_bs_adr_bits_way, io_bs_adr_bits_set,
             io_bs_adr_bits_beat, io_bs_adr_bits_mask, io_c_valid,
             io_c_bits_opcode, io_c_bits_param, io_c_bits_size,
             io_c_bits_source, io_c_bits_address, io_c_bits_data,
             io_c_bits_corrupt, io_busy
   );

endinterface

// File: rtl/source_c_beat_fifo.sv
// First-word-fall-through beat FIFO; count_o feeds the issue credit.
// Ports: write side (wr_*), read side (rd_*), occupancy count_o.
module source_c_beat_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         wr_valid_i,
   input  logic [W-1:0]                 wr_data_i,
   output logic                         rd_valid_o,
   input  logic                         rd_ready_i,
   output logic [W-1:0]                 rd_data_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          wr_en, rd_en;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign rd_valid_o = (cnt_q != '0);
   assign rd_data_o  = mem_q[rp_q];
   assign count_o    = cnt_q;
   assign wr_en      = wr_valid_i && (cnt_q != CW'(DEPTH));
   assign rd_en      = rd_valid_o && rd_ready_i;

   always_comb begin
      wp_d  = wr_en ? inc(wp_q) : wp_q;
      rp_d  = rd_en ? inc(rp_q) : rp_q;
      cnt_d = cnt_q;
      unique case ({wr_en, rd_en})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en) mem_q[wp_q] <= wr_data_i;
   end

endmodule

// File: rtl/source_c.sv
// Outbound TileLink C source: turns MSHR release/probe-ack requests into
// ordered C beats. Ports: clock, reset (async low), io bundle (source_c_if).
module source_c
   import source_c_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   source_c_if.master io
);

   state_e            state_q, state_d;
   req_t              req_q, req_d;
   logic [BEAT_W-1:0] cnt_q, cnt_d;
   logic [BS_LAT-1:0] pv_q, pd_q;
   beat_t             ph_q [BS_LAT];

   logic              req_fire, has_data, last, credit, slot;
   logic              pipe_exit, fifo_valid;
   logic [CNT_W-1:0]  fifo_cnt;
   logic [FILL_W-1:0] fill;
   beat_t             hdr, enq_beat, deq_beat;

   assign req_fire = io.io_req_valid && io.io_req_ready;
   assign has_data = req_q.opcode[0];
   assign last     = !has_data || (cnt_q == BEAT_W'(BLOCK_BEATS - 1));

   // Credit counts beats in flight through the pipe so a slot never
   // issues without a guaranteed FIFO entry; all terms are registered.
   always_comb begin
      fill = FILL_W'(fifo_cnt);
      for (int i = 0; i < BS_LAT; i++) fill = fill + FILL_W'(pv_q[i]);
   end
   assign credit = (fill < FILL_W'(DEPTH));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (req_fire) state_d = ISSUE;
         ISSUE:   if (slot && last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      io.io_req_ready    = 1'b0;
      io.io_bs_adr_valid = 1'b0;
      slot               = 1'b0;
      unique case (state_q)
         IDLE:    io.io_req_ready = reset;
         ISSUE: begin
            io.io_bs_adr_valid = has_data && credit;
            slot = has_data ? (credit && io.io_bs_adr_ready) : credit;
         end
         default: ;
      endcase
   end

   always_comb begin
      req_d = req_q;
      cnt_d = cnt_q;
      if (req_fire) begin
         req_d = '{opcode: io.io_req_bits_opcode,
                   param:  io.io_req_bits_param,
                   source: io.io_req_bits_source,
                   tag:    io.io_req_bits_tag,
                   set:    io.io_req_bits_set,
                   way:    io.io_req_bits_way};
         cnt_d = '0;
      end else if (slot) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         req_q <= '0;
         cnt_q <= '0;
      end else begin
         req_q <= req_d;
         cnt_q <= cnt_d;
      end
   end

   assign hdr = '{opcode:  req_q.opcode,
                  param:   req_q.param,
                  source:  req_q.source,
                  address: block_addr(req_q.tag, req_q.set),
                  data:    '0};

   // Dataless slots ride the same pipe so they stay behind earlier beats.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pv_q <= '0;
         pd_q <= '0;
         for (int i = 0; i < BS_LAT; i++) ph_q[i] <= '0;
      end else begin
         pv_q    <= {pv_q[BS_LAT-2:0], slot};
         pd_q    <= {pd_q[BS_LAT-2:0], has_data};
         ph_q[0] <= hdr;
         for (int i = 1; i < BS_LAT; i++) ph_q[i] <= ph_q[i-1];
      end
   end

   assign pipe_exit = pv_q[BS_LAT-1];

   always_comb begin
      enq_beat = ph_q[BS_LAT-1];
      if (pd_q[BS_LAT-1]) enq_beat.data = io.io_bs_dat_data;
   end

   source_c_beat_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(beat_t))
   ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .wr_valid_i (pipe_exit),
      .wr_data_i  (enq_beat),
      .rd_valid_o (fifo_valid),
      .rd_ready_i (io.io_c_ready),
      .rd_data_o  (deq_beat),
      .count_o    (fifo_cnt)
   );

   assign io.io_bs_adr_bits_noop = 1'b0;
   assign io.io_bs_adr_bits_way  = req_q.way;
   assign io.io_bs_adr_bits_set  = req_q.set;
   assign io.io_bs_adr_bits_beat = cnt_q;
   assign io.io_bs_adr_bits_mask = 2'b11;

   assign io.io_c_valid        = fifo_valid;
   assign io.io_c_bits_opcode  = deq_beat.opcode;
   assign io.io_c_bits_param   = deq_beat.param;
   assign io.io_c_bits_size    = 3'(BLOCK_SIZE_LG);
   assign io.io_c_bits_source  = deq_beat.source;
   assign io.io_c_bits_address = deq_beat.address;
   assign io.io_c_bits_data    = deq_beat.data;
   assign io.io_c_bits_corrupt = 1'b0;

   assign io.io_busy = (state_q == ISSUE) || (|pv_q) || fifo_valid;

endmodule

// File: tb/tb_source_c.sv
// Self-checking bench for source_c: directed cases plus a random stream,
// expected beats queued at request time and checked by a C-side monitor.
module tb_source_c;
   import source_c_pkg::*;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   source_c_if bus();
   source_c dut (.clock(clock), .reset(reset), .io(bus));

   int checks = 0;
   int errors = 0;
   int pops = 0;
   int adr_fires = 0;
   int c_mode = 1;
   int adr_mode = 1;
   bit tog = 1'b0;
   bit ovf = 1'b0;
   beat_t sb[$];

   function automatic logic [127:0] bank_word(
      input logic [2:0] w, input logic [9:0] s, input logic [1:0] b);
      return {{8{w, s, b}}, 8'hA5};
   endfunction

   // Banked store: data appears two cycles after each adr handshake.
   logic [127:0] bk_q [2];
   always @(posedge clock) begin
      if (bus.io_bs_adr_valid && bus.io_bs_adr_ready) begin
         bk_q[0] <= bank_word(bus.io_bs_adr_bits_way,
                              bus.io_bs_adr_bits_set,
                              bus.io_bs_adr_bits_beat);
         adr_fires++;
      end else begin
         bk_q[0] <= {4{32'hDEADBEEF}};
      end
      bk_q[1] <= bk_q[0];
   end
   assign bus.io_bs_dat_data = bk_q[1];

   always @(posedge clock) begin
      #1;
      tog = !tog;
      case (c_mode)
         0:       bus.io_c_ready = 1'b0;
         1:       bus.io_c_ready = 1'b1;
         default: bus.io_c_ready = 1'($urandom_range(0, 1));
      endcase
      case (adr_mode)
         1:       bus.io_bs_adr_ready = 1'b1;
         2:       bus.io_bs_adr_ready = tog;
         default: bus.io_bs_adr_ready = 1'($urandom_range(0, 1));
      endcase
   end

   bit    held = 1'b0;
   beat_t held_b;
   always @(negedge clock) begin
      beat_t cur, want;
      if (reset && dut.fifo_cnt == CNT_W'(DEPTH) && dut.pipe_exit) ovf = 1'b1;
      if (!reset) begin
         held = 1'b0;
      end else if (bus.io_c_valid) begin
         cur = '{opcode:  bus.io_c_bits_opcode,
                 param:   bus.io_c_bits_param,
                 source:  bus.io_c_bits_source,
                 address: bus.io_c_bits_address,
                 data:    bus.io_c_bits_data};
         if (held) begin
            checks++;
            if (cur !== held_b) begin
               errors++;
               $display("FAIL hdr_stable got addr=%h op=%0d want addr=%h op=%0d",
                        cur.address, cur.opcode, held_b.address, held_b.opcode);
            end
         end
         held   = !bus.io_c_ready;
         held_b = cur;
         if (bus.io_c_ready) begin
            checks++;
            pops++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL c_beat got unexpected addr=%h op=%0d want none",
                        cur.address, cur.opcode);
            end else begin
               want = sb.pop_front();
               if (cur !== want || bus.io_c_bits_size !== 3'd6 ||
                   bus.io_c_bits_corrupt !== 1'b0) begin
                  errors++;
                  $display("FAIL c_beat got op=%0d prm=%0d src=%h addr=%h data=%h sz=%0d want op=%0d prm=%0d src=%h addr=%h data=%h sz=6",
                           cur.opcode, cur.param, cur.source, cur.address,
                           cur.data, bus.io_c_bits_size, want.opcode,
                           want.param, want.source, want.address, want.data);
               end
            end
         end
      end else begin
         held = 1'b0;
      end
   end

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", name, got, want);
      end
   endtask

   task automatic send(input logic [2:0] op, input logic [2:0] prm,
                       input logic [5:0] src, input logic [11:0] tg,
                       input logic [9:0] st, input logic [2:0] wy);
      int n;
      @(negedge clock);
      bus.io_req_valid       = 1'b1;
      bus.io_req_bits_opcode = op;
      bus.io_req_bits_param  = prm;
      bus.io_req_bits_source = src;
      bus.io_req_bits_tag    = tg;
      bus.io_req_bits_set    = st;
      bus.io_req_bits_way    = wy;
      n = 0;
      while (!bus.io_req_ready && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL req_accept got timeout want ready");
         bus.io_req_valid = 1'b0;
         return;
      end
      for (int b = 0; b < (op[0] ? 4 : 1); b++)
         sb.push_back('{opcode: op, param: prm, source: src,
                        address: {4'h0, tg, st, 6'h00},
                        data: op[0] ? bank_word(wy, st, 2'(b)) : 128'h0});
      @(posedge clock);
      #1 bus.io_req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || bus.io_busy) && n < 5000) begin
         @(negedge clock);
         n++;
      end
      chk("drain_timeout", 32'(n >= 5000), 32'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int f0, p0, lat, stall_adr;
      reset = 1'b0;
      bus.io_req_valid       = 1'b0;
      bus.io_req_bits_opcode = '0;
      bus.io_req_bits_param  = '0;
      bus.io_req_bits_source = '0;
      bus.io_req_bits_tag    = '0;
      bus.io_req_bits_set    = '0;
      bus.io_req_bits_way    = '0;
      bus.io_c_ready         = 1'b1;
      bus.io_bs_adr_ready    = 1'b1;
      repeat (3) @(negedge clock);
      chk("rst_req_ready", 32'(bus.io_req_ready), 0);
      chk("rst_c_valid", 32'(bus.io_c_valid), 0);
      chk("rst_adr_valid", 32'(bus.io_bs_adr_valid), 0);
      chk("rst_busy", 32'(bus.io_busy), 0);
      reset = 1'b1;
      #1 chk("post_rst_req_ready", 32'(bus.io_req_ready), 1);

      // ReleaseData, no backpressure
      f0 = adr_fires;
      send(RELEASE_DATA, 3'd0, 6'h05, 12'hABC, 10'h155, 3'd5);
      lat = 0;
      do begin
         @(posedge clock);
         lat++;
         @(negedge clock);
      end while (!bus.io_c_valid && lat < 20);
      chk("rd_latency", 32'(lat), 32'd3);
      chk("rd_address", bus.io_c_bits_address, 32'h0ABC5540);
      chk("rd_opcode", 32'(bus.io_c_bits_opcode), 32'd7);
      drain();
      chk("rd_adr_reads", 32'(adr_fires - f0), 32'd4);

      // ProbeAck: one dataless beat, ready back the next cycle
      f0 = adr_fires;
      send(PROBE_ACK, 3'd3, 6'h21, 12'h123, 10'h2AA, 3'd1);
      @(negedge clock);
      chk("pa_ready_issue", 32'(bus.io_req_ready), 0);
      @(negedge clock);
      chk("pa_ready_back", 32'(bus.io_req_ready), 1);
      drain();
      chk("pa_adr_reads", 32'(adr_fires - f0), 32'd0);

      // Stall on C with ReleaseData then ProbeAck
      c_mode = 0;
      p0 = pops;
      send(RELEASE_DATA, 3'd1, 6'h11, 12'h0F1, 10'h3C3, 3'd6);
      send(PROBE_ACK, 3'd2, 6'h12, 12'h0F2, 10'h0C4, 3'd0);
      stall_adr = 0;
      repeat (20) begin
         @(negedge clock);
         if (bus.io_bs_adr_valid) stall_adr++;
      end
      chk("stall_adr_valid", 32'(stall_adr), 0);
      chk("stall_fill", 32'(dut.fifo_cnt), 32'd4);
      chk("stall_req_ready", 32'(bus.io_req_ready), 0);
      chk("stall_c_valid", 32'(bus.io_c_valid), 1);
      c_mode = 1;
      drain();
      chk("stall_beats", 32'(pops - p0), 32'd5);

      // ProbeAckData with alternating store grant
      adr_mode = 2;
      f0 = adr_fires;
      send(PROBE_ACK_DATA, 3'd1, 6'h0A, 12'h321, 10'h0F0, 3'd2);
      drain();
      chk("pad_adr_reads", 32'(adr_fires - f0), 32'd4);
      adr_mode = 1;

      // Reset in the middle of a ReleaseData
      p0 = pops;
      send(RELEASE_DATA, 3'd0, 6'h33, 12'h777, 10'h111, 3'd3);
      lat = 0;
      while (pops - p0 < 2 && lat < 50) begin
         @(negedge clock);
         #1 lat++;
      end
      reset = 1'b0;
      #1 chk("mid_rst_c_valid", 32'(bus.io_c_valid), 0);
      sb.delete();
      @(negedge clock);
      reset = 1'b1;
      #1 chk("mid_rst_busy", 32'(bus.io_busy), 0);
      p0 = pops;
      send(RELEASE, 3'd4, 6'h3F, 12'h456, 10'h222, 3'd7);
      drain();
      repeat (5) @(negedge clock);
      chk("post_rst_beats", 32'(pops - p0), 32'd1);

      // Random mixed stream with random backpressure
      c_mode = 2;
      adr_mode = 3;
      for (int i = 0; i < 1000; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clock);
         send(3'(4 + $urandom_range(0, 3)), 3'($urandom), 6'($urandom),
              12'($urandom), 10'($urandom), 3'($urandom));
      end
      drain();
      chk("sb_empty", 32'(sb.size()), 0);
      chk("fifo_overflow", 32'(ovf), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
